// File: rtl/lfsr_rng_bank_pkg.sv
// Shared constants, FSM state type and helper functions for the LFSR random bank.
// The output bit-index function is used by both the RTL mapping and the bench model.
package lfsr_rng_pkg;

    localparam logic [15:0] DEF_TAP_MASK = 16'h8016;
    localparam logic [15:0] DEF_SEED_RST = 16'hACE1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Bit j of output word k comes from D[(k + j*S) mod w], with odd stride S = 1 + 2*(k div w).
    function automatic int out_bit_idx(input int k, input int j, input int w);
        return (k + j * (1 + 2 * (k / w))) % w;
    endfunction

    function automatic logic xor_reduce32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_rng_bank_if.sv
// Control/status bundle for the LFSR random bank: seed/burst controls in, handshake and words out.
interface lfsr_rng_bank_if #(
    parameter int LFSR_W  = 16,
    parameter int NUM_OUT = 32,
    parameter int OUT_W   = 8,
    parameter int CNT_W   = 16
) ();
    logic                     EN;
    logic                     LOAD;
    logic [LFSR_W-1:0]        SEED;
    logic                     START;
    logic [CNT_W-1:0]         LEN;
    logic                     BUSY;
    logic                     DONE;
    logic                     LOCKUP;
    logic                     VALID;
    logic [NUM_OUT*OUT_W-1:0] OUT;

    modport master (
        output EN, LOAD, SEED, START, LEN,
        input  BUSY, DONE, LOCKUP, VALID, OUT
    );

    modport slave (
        input  EN, LOAD, SEED, START, LEN,
        output BUSY, DONE, LOCKUP, VALID, OUT
    );
endinterface

// File: rtl/lfsr_rng_bank_core.sv
// Fibonacci LFSR state register with seed load; a zero seed is replaced by the reset seed
// and flagged, so the all-zero lock-up state can never be entered.
module lfsr_core
    import lfsr_rng_pkg::*;
#(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(DEF_TAP_MASK),
    parameter logic [LFSR_W-1:0] SEED_RST = LFSR_W'(DEF_SEED_RST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] d,
    output logic              lockup
);

    logic [LFSR_W-1:0] d_r;
    logic              lockup_r;
    logic              fb_s;
    logic              seed_zero_s;

    // Feedback tap parity and zero-seed detect
    always_comb begin
        fb_s        = xor_reduce32(32'(d_r & TAP_MASK));
        seed_zero_s = (seed == {LFSR_W{1'b0}});
    end

    // State register: reset > load > step
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r      <= SEED_RST;
            lockup_r <= 1'b0;
        end else if (load) begin
            if (seed_zero_s) begin
                d_r      <= SEED_RST;
                lockup_r <= 1'b1;
            end else begin
                d_r      <= seed;
                lockup_r <= 1'b0;
            end
        end else if (step) begin
            d_r      <= {d_r[LFSR_W-2:0], fb_s};
            lockup_r <= 1'b0;
        end else begin
            lockup_r <= 1'b0;
        end
    end

    assign d      = d_r;
    assign lockup = lockup_r;

endmodule

// File: rtl/lfsr_rng_bank.sv
// Bank of NUM_OUT decorrelated random words from one LFSR, with free-run enable,
// seed load and a counted burst mode reporting BUSY/DONE.
module lfsr_rng_bank
    import lfsr_rng_pkg::*;
#(
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAP_MASK = LFSR_W'(DEF_TAP_MASK),
    parameter logic [LFSR_W-1:0] SEED_RST = LFSR_W'(DEF_SEED_RST),
    parameter int                NUM_OUT  = 32,
    parameter int                OUT_W    = 8,
    parameter int                CNT_W    = 16
) (
    input  logic         TRIG,
    input  logic         RESET,
    lfsr_rng_bank_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                   state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     valid_r;
    logic                     step_s;
    logic                     lockup_s;
    logic [LFSR_W-1:0]        d_s;
    logic [NUM_OUT*OUT_W-1:0] out_s;

    // Step decision; the START cycle in IDLE never steps, and EN is ignored during a burst
    always_comb begin
        step_s = 1'b0;
        if (RESET || bus.LOAD) begin
            step_s = 1'b0;
        end else if (state_r == BURST) begin
            step_s = 1'b1;
        end else if (bus.EN && !bus.START) begin
            step_s = 1'b1;
        end else begin
            step_s = 1'b0;
        end
    end

    lfsr_core #(
        .LFSR_W   (LFSR_W),
        .TAP_MASK (TAP_MASK),
        .SEED_RST (SEED_RST)
    ) u_core (
        .clk    (TRIG),
        .rst    (RESET),
        .load   (bus.LOAD),
        .step   (step_s),
        .seed   (bus.SEED),
        .d      (d_s),
        .lockup (lockup_s)
    );

    // Burst FSM with counter and registered handshake flags
    always_ff @(posedge TRIG) begin
        if (RESET) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= step_s;
            if (bus.LOAD) begin
                state_r <= IDLE;
                cnt_r   <= CNT_ZERO;
                busy_r  <= 1'b0;
                done_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.START && (bus.LEN != CNT_ZERO)) begin
                            state_r <= BURST;
                            cnt_r   <= bus.LEN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end else if (bus.START) begin
                            done_r  <= 1'b1;
                        end else begin
                            done_r  <= 1'b0;
                        end
                    end
                    BURST: begin
                        if (cnt_r == CNT_ONE) begin
                            state_r <= IDLE;
                            cnt_r   <= CNT_ZERO;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            cnt_r   <= cnt_r - CNT_ONE;
                            done_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pure wiring from the state register: each word samples D with its own stride
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_word
        for (genvar j = 0; j < OUT_W; j++) begin : g_bit
            localparam int IDX = out_bit_idx(k, j, LFSR_W);
            assign out_s[k*OUT_W + j] = d_s[IDX];
        end
    end

    assign bus.OUT    = out_s;
    assign bus.BUSY   = busy_r;
    assign bus.DONE   = done_r;
    assign bus.LOCKUP = lockup_s;
    assign bus.VALID  = valid_r;

endmodule
